// File: rtl/mac_ofm_packer.sv
// ============================================================================
// Module   : mac_ofm_packer
// Brief    : Final OFM stage after the MAC psum accumulator. Applies optional
//            ReLU, then either passes fp32 through or rounds to bf16 (RNE) and
//            packs two bf16 elements per 32-bit word. An odd element at the
//            end of a tile is flushed as a half word with zero upper padding.
// Options  : MAC_OFM_PACK_STAT_EN - enables the saturating ReLU clamp counter
//            on o_stat_relu_cnt (tied to zero when undefined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_ofm_packer #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_relu_enable,
  input  logic              i_out_format,
  output logic              o_idle,
  output logic              o_input_ready,
  input  logic              i_input_valid,
  input  logic [DATA_W-1:0] i_input_data,
  input  logic              i_input_end,
  input  logic              i_output_ready,
  output logic              o_output_valid,
  output logic [DATA_W-1:0] o_output_data,
  output logic              o_output_last,
  output logic              o_output_half,
  output logic [31:0]       o_stat_relu_cnt
);

  localparam logic [14:0] c_bf16_qnan_mag = 15'h7FC0;

  // Output word register and the pending low half of a bf16 pair
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_half;
  logic [15:0]       r_lo;
  logic              r_lo_valid;
  logic              r_lo_end;

  logic              w_in_nan;
  logic              w_clamp;
  logic [DATA_W-1:0] w_relu;
  logic              w_relu_nan;
  logic              w_round_up;
  logic [15:0]       w_bf16;
  logic              w_out_free;
  logic              w_ready;
  logic              w_accept;
  logic              w_flush;
  logic              w_load_fp32;
  logic              w_load_pair;
  logic              w_load_lo;
  logic              w_load;
  logic [DATA_W-1:0] w_load_data;

  // ReLU: negative non-NaN values (including -0 and -Inf) become +0
  assign w_in_nan = (&i_input_data[30:23]) & (|i_input_data[22:0]);
  assign w_clamp  = i_relu_enable & i_input_data[31] & ~w_in_nan;
  assign w_relu   = w_clamp ? '0 : i_input_data;

  // bf16 round-to-nearest-even; a carry into the exponent rounds to Inf.
  // NaN collapses to a quiet NaN keeping the sign.
  assign w_relu_nan = (&w_relu[30:23]) & (|w_relu[22:0]);
  assign w_round_up = w_relu[15] & (w_relu[16] | (|w_relu[14:0]));
  assign w_bf16     = w_relu_nan ? {w_relu[31], c_bf16_qnan_mag}
                                 : (w_relu[31:16] + {15'd0, w_round_up});

  // Handshake. While a tile-end half is pending, input stalls until it has
  // been flushed so a pair never straddles two tiles.
  assign w_out_free = ~r_out_valid | i_output_ready;
  assign w_ready    = i_out_format ? (r_lo_valid ? (w_out_free & ~r_lo_end) : 1'b1)
                                   : w_out_free;
  assign w_accept   = i_input_valid & w_ready;

  // Flush and pair-load are mutually exclusive: a pending end blocks input
  assign w_flush     = i_out_format & r_lo_valid & r_lo_end & w_out_free;
  assign w_load_fp32 = w_accept & ~i_out_format;
  assign w_load_pair = w_accept & i_out_format & r_lo_valid;
  assign w_load_lo   = w_accept & i_out_format & ~r_lo_valid;
  assign w_load      = w_load_fp32 | w_load_pair | w_flush;
  assign w_load_data = w_flush     ? {16'h0000, r_lo} :
                       w_load_pair ? {w_bf16, r_lo}   : w_relu;

  // Output register: load new word, or drop valid once it has been taken
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_half  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_load_data;
      r_out_last  <= w_flush | i_input_end;
      r_out_half  <= w_flush;
    end else if (i_output_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Pending half: holds the first bf16 element of a pair (or a tile tail)
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lo       <= '0;
      r_lo_valid <= 1'b0;
      r_lo_end   <= 1'b0;
    end else if (w_load_lo) begin
      r_lo       <= w_bf16;
      r_lo_valid <= 1'b1;
      r_lo_end   <= i_input_end;
    end else if (w_load_pair | w_flush) begin
      r_lo_valid <= 1'b0;
      r_lo_end   <= 1'b0;
    end
  end

`ifdef MAC_OFM_PACK_STAT_EN
  logic [31:0] r_stat_relu_cnt;
  logic        w_stat_inc;

  // Only real clamps count: a -0 input is already zero in magnitude
  assign w_stat_inc = w_accept & w_clamp & (|i_input_data[30:0]);

  // Saturating clamp counter, cleared only by reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stat_relu_cnt <= '0;
    end else if (w_stat_inc && (r_stat_relu_cnt != 32'hFFFF_FFFF)) begin
      r_stat_relu_cnt <= r_stat_relu_cnt + 32'd1;
    end
  end

  assign o_stat_relu_cnt = r_stat_relu_cnt;
`else
  assign o_stat_relu_cnt = 32'd0;
`endif

  assign o_idle         = ~r_out_valid & ~r_lo_valid;
  assign o_input_ready  = w_ready;
  assign o_output_valid = r_out_valid;
  assign o_output_data  = r_out_data;
  assign o_output_last  = r_out_last;
  assign o_output_half  = r_out_half;

endmodule

`default_nettype wire

// File: tb/tb_mac_ofm_packer.sv
// ============================================================================
// Module   : tb_mac_ofm_packer
// Brief    : Scoreboard bench for mac_ofm_packer. A reference model computes
//            each expected output word when an element is accepted; a monitor
//            pops and compares whenever the DUT hands over a word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_ofm_packer;

`ifdef MAC_OFM_PACK_STAT_EN
  localparam bit c_stat_en = 1'b1;
`else
  localparam bit c_stat_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_relu_enable = 1'b0;
  logic        i_out_format = 1'b0;
  logic        o_idle;
  logic        o_input_ready;
  logic        i_input_valid = 1'b0;
  logic [31:0] i_input_data = '0;
  logic        i_input_end = 1'b0;
  logic        i_output_ready = 1'b0;
  logic        o_output_valid;
  logic [31:0] o_output_data;
  logic        o_output_last;
  logic        o_output_half;
  logic [31:0] o_stat_relu_cnt;

  mac_ofm_packer #(.DATA_W(32)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_relu_enable   (i_relu_enable),
    .i_out_format    (i_out_format),
    .o_idle          (o_idle),
    .o_input_ready   (o_input_ready),
    .i_input_valid   (i_input_valid),
    .i_input_data    (i_input_data),
    .i_input_end     (i_input_end),
    .i_output_ready  (i_output_ready),
    .o_output_valid  (o_output_valid),
    .o_output_data   (o_output_data),
    .o_output_last   (o_output_last),
    .o_output_half   (o_output_half),
    .o_stat_relu_cnt (o_stat_relu_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        half;
  } word_t;

  word_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          m_pend_valid = 1'b0;
  logic [15:0] m_pend = '0;
  int unsigned m_stat = 0;
  int          rdy_pct = 100;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] m_relu(input logic [31:0] x, input bit en);
    if (en && x[31] && !m_is_nan(x)) return 32'h0;
    return x;
  endfunction

  // Nearest-even rounding done arithmetically on the truncated value
  function automatic logic [15:0] m_bf16(input logic [31:0] x);
    int unsigned t;
    int unsigned r;
    if (m_is_nan(x)) return {x[31], 15'h7FC0};
    t = x >> 16;
    r = x & 32'hFFFF;
    if (r > 32'h8000 || (r == 32'h8000 && (t % 2) == 1)) t = t + 1;
    return t[15:0];
  endfunction

  task automatic model_accept(input logic [31:0] d, input bit e);
    logic [31:0] y;
    logic [15:0] b;
    y = m_relu(d, i_relu_enable);
    if (i_relu_enable && d[31] && !m_is_nan(d) && d[30:0] != 31'd0 && m_stat != 32'hFFFF_FFFF)
      m_stat++;
    if (!i_out_format) begin
      exp_q.push_back('{data: y, last: e, half: 1'b0});
    end else begin
      b = m_bf16(y);
      if (!m_pend_valid) begin
        if (e) exp_q.push_back('{data: {16'h0000, b}, last: 1'b1, half: 1'b1});
        else begin
          m_pend = b;
          m_pend_valid = 1'b1;
        end
      end else begin
        exp_q.push_back('{data: {b, m_pend}, last: e, half: 1'b0});
        m_pend_valid = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] exp_stat();
    return c_stat_en ? m_stat : 32'd0;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    bit    have_prev;
    word_t prev;
    word_t cur;
    word_t e;
    have_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        have_prev = 1'b0;
        continue;
      end
      cur = '{data: o_output_data, last: o_output_last, half: o_output_half};
      if (have_prev) begin
        check("hold_valid", {63'd0, o_output_valid}, 64'd1);
        check("hold_word", {30'd0, cur}, {30'd0, prev});
      end
      if (o_output_valid && i_output_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {30'd0, cur}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {30'd0, cur}, {30'd0, e});
        end
      end
      have_prev = o_output_valid && !i_output_ready;
      prev = cur;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [31:0] d, input bit e, input bit rdy, output bit acc);
    @(negedge clk);
    i_output_ready = rdy;
    i_input_valid  = v;
    i_input_data   = d;
    i_input_end    = e;
    #1;
    acc = v && o_input_ready;
    if (acc) model_accept(d, e);
  endtask

  task automatic send(input logic [31:0] d, input bit e);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++)
      step(1'b1, d, e, ($urandom_range(0, 99) < rdy_pct), acc);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_step();
    bit acc;
    step(1'b0, 32'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      idle_step();
      done = o_idle;
    end
    if (!done) check("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic set_mode(input bit fmt, input bit relu);
    wait_idle();
    i_out_format  = fmt;
    i_relu_enable = relu;
  endtask

  function automatic logic [31:0] rand_elem();
    logic [31:0] sp [8];
    int sel;
    sp = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
           32'h7FC0_0000, 32'hFFC0_0001, 32'h7F7F_FFFF, 32'hFF7F_FFFF};
    sel = $urandom_range(0, 9);
    if (sel < 2) return sp[$urandom_range(0, 7)];
    if (sel < 4) return {$urandom_range(0, 65535) & 32'hFFFF, 16'h8000} ;
    return $urandom;
  endfunction

  initial begin : stim
    bit acc;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {63'd0, o_output_valid}, 64'd0);
    check("rst_data", {32'd0, o_output_data}, 64'd0);
    check("rst_last_half", {62'd0, o_output_last, o_output_half}, 64'd0);
    check("rst_idle", {63'd0, o_idle}, 64'd1);
    check("rst_stat", {32'd0, o_stat_relu_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // fp32 passthrough, one-cycle latency
    set_mode(1'b0, 1'b0);
    rdy_pct = 100;
    send(32'h3F80_0000, 1'b0);
    idle_step();
    check("fp32_lat_valid", {63'd0, o_output_valid}, 64'd1);
    send(32'hBF80_0000, 1'b1);
    idle_step();
    check("fp32_lat_last", {62'd0, o_output_valid, o_output_last}, 64'd3);

    // fp32 with ReLU: -1 clamps, -0 becomes +0 (not counted), NaN passes
    set_mode(1'b0, 1'b1);
    send(32'hBF80_0000, 1'b0);
    send(32'h8000_0000, 1'b0);
    send(32'hFFC0_0000, 1'b1);
    wait_idle();
    check("stat_relu_fp32", {32'd0, o_stat_relu_cnt}, {32'd0, exp_stat()});

    // bf16 rounding and packing order
    set_mode(1'b1, 1'b0);
    send(32'h3F80_8000, 1'b0);
    send(32'h3F81_8000, 1'b0);
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7FC0_0001, 1'b1);
    wait_idle();

    // bf16 odd tail: half word appears two cycles after the tail accept
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b0);
    send(32'h4080_0000, 1'b1);
    idle_step();
    check("tail_gap", {63'd0, o_output_valid}, 64'd0);
    idle_step();
    check("tail_lat", {61'd0, o_output_valid, o_output_half, o_output_last}, 64'd7);
    wait_idle();

    // Backpressure: one extra element fits in the pending half, then stall
    rdy_pct = 0;
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    step(1'b1, 32'h4040_0000, 1'b0, 1'b0, acc);
    check("bp_one_more", {63'd0, acc}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'h4080_0000, 1'b1, 1'b0, acc);
      check("bp_blocked", {63'd0, o_input_ready}, 64'd0);
    end
    rdy_pct = 100;
    send(32'h4080_0000, 1'b1);
    wait_idle();

    // Randomized blocks; each block closes its last tile
    for (int blk = 0; blk < 20; blk++) begin
      set_mode($urandom_range(0, 1), $urandom_range(0, 1));
      rdy_pct = $urandom_range(30, 100);
      for (int n = 0; n < 30; n++)
        send(rand_elem(), (n == 29) || ($urandom_range(0, 5) == 0));
      wait_idle();
      check("stat_block", {32'd0, o_stat_relu_cnt}, {32'd0, exp_stat()});
    end

    // Reset with a held word and a pending half
    set_mode(1'b1, 1'b1);
    rdy_pct = 0;
    send(32'hBF80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    send(32'h4040_0000, 1'b0);
    @(negedge clk);
    check("pre_rst_busy", {62'd0, o_output_valid, o_idle}, 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, o_output_valid}, 64'd0);
    check("mid_rst_data", {29'd0, o_output_data, o_output_last, o_output_half, o_idle}, 64'd1);
    check("mid_rst_stat", {32'd0, o_stat_relu_cnt}, 64'd0);
    exp_q.delete();
    m_pend_valid = 1'b0;
    m_stat = 0;
    @(negedge clk);
    rst = 1'b0;
    i_input_valid = 1'b0;
    rdy_pct = 100;
    send(32'h3F81_8000, 1'b0);
    send(32'h3F80_8000, 1'b1);
    wait_idle();

    check("queue_drained", exp_q.size(), 64'd0);
    check("stat_final", {32'd0, o_stat_relu_cnt}, {32'd0, exp_stat()});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
